// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared defaults, state encoding and tick divisor helper for the UART receiver
package uart_rx_pkg;
  localparam int NBIT_DATA_DEF = 8;
  localparam int NUM_TICKS_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11} state_t;
  function automatic int tick_div(input int clk_freq, input int baud_rate, input int num_ticks);
    return (clk_freq + (baud_rate * num_ticks) / 2) / (baud_rate * num_ticks);
  endfunction
endpackage

// File: rtl/uart_rx_baud_tick_gen.sv
// baud_tick_gen: free-running oversampling tick, one-cycle pulse every DIV clocks
module baud_tick_gen
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int NUM_TICKS = NUM_TICKS_DEF
) (
  input  logic CLK,
  input  logic RESET,
  output logic s_tick
);
  localparam int DIV = tick_div(CLK_FREQ, BAUD_RATE, NUM_TICKS);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt;
  assign s_tick = cnt == LAST;
  always_ff @(posedge CLK)
    cnt <= RESET ? '0 : s_tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 2-FF input synchronizer and framing error detection
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int NBIT_DATA = NBIT_DATA_DEF,
  parameter int NUM_TICKS = NUM_TICKS_DEF,
  parameter int BAUD_RATE = 9600,
  parameter int CLK_FREQ  = 50000000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 rx_bit,
  output logic [NBIT_DATA-1:0] data_out,
  output logic                 rx_done_tick,
  output logic                 frame_err_tick,
  output logic                 busy
);
  localparam int SW = $clog2(NUM_TICKS);
  localparam int NW = NBIT_DATA > 1 ? $clog2(NBIT_DATA) : 1;
  localparam logic [SW-1:0] S_HALF = SW'(NUM_TICKS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(NUM_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NBIT_DATA - 1);
  state_t state, state_n;
  logic [1:0] sync;
  logic rx_s, s_tick, done_n, err_n;
  logic [SW-1:0] s_cnt, s_n;
  logic [NW-1:0] n_cnt, n_n;
  logic [NBIT_DATA-1:0] shreg, b_n, d_n;
  baud_tick_gen #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .NUM_TICKS(NUM_TICKS)) u_tick (
    .CLK(CLK), .RESET(RESET), .s_tick(s_tick)
  );
  assign rx_s = sync[1];
  assign busy = state != IDLE;
  always_ff @(posedge CLK)
    if (RESET) begin
      state <= IDLE;
      sync <= 2'b11;
      s_cnt <= '0;
      n_cnt <= '0;
      shreg <= '0;
      data_out <= '0;
      rx_done_tick <= 1'b0;
      frame_err_tick <= 1'b0;
    end else begin
      state <= state_n;
      sync <= {sync[0], rx_bit};
      s_cnt <= s_n;
      n_cnt <= n_n;
      shreg <= b_n;
      data_out <= d_n;
      rx_done_tick <= done_n;
      frame_err_tick <= err_n;
    end
  always_comb begin
    state_n = state;
    s_n = s_cnt;
    n_n = n_cnt;
    b_n = shreg;
    d_n = data_out;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE:
        if (!rx_s) begin
          state_n = START;
          s_n = '0;
        end
      START:
        if (s_tick) begin
          if (s_cnt == S_HALF) begin
            state_n = rx_s ? IDLE : DATA;
            s_n = '0;
            n_n = '0;
          end else s_n = s_cnt + 1'b1;
        end
      DATA:
        if (s_tick) begin
          if (s_cnt == S_LAST) begin
            b_n = NBIT_DATA'({rx_s, shreg} >> 1);
            s_n = '0;
            state_n = n_cnt == N_LAST ? STOP : DATA;
            n_n = n_cnt == N_LAST ? n_cnt : n_cnt + 1'b1;
          end else s_n = s_cnt + 1'b1;
        end
      STOP:
        if (s_tick) begin
          if (s_cnt == S_LAST) begin
            d_n = rx_s ? shreg : data_out;
            done_n = rx_s;
            err_n = !rx_s;
            state_n = IDLE;
            s_n = '0;
          end else s_n = s_cnt + 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frame checks plus glitch, back-to-back, reset and stuck-low sequences
module tb_uart_rx;
  localparam int T = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic [7:0] data_out;
  logic rx_done_tick, frame_err_tick, busy;
  int n_chk = 0, n_fail = 0;
  int n_done = 0, n_err = 0, n_both = 0;
  logic [7:0] got[$];
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_dout;
  } vec_t;
  vec_t vecs[6];
  uart_rx #(.NBIT_DATA(8), .NUM_TICKS(16), .BAUD_RATE(9600), .CLK_FREQ(614400)) dut (
    .CLK(clk), .RESET(rst), .rx_bit(rx), .data_out(data_out),
    .rx_done_tick(rx_done_tick), .frame_err_tick(frame_err_tick), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_done_tick) begin
      n_done++;
      got.push_back(data_out);
    end
    if (frame_err_tick) n_err++;
    if (rx_done_tick && frame_err_tick) n_both++;
  end
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    wait_cyc(T);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(T);
    end
    rx = stop;
    wait_cyc(T);
    rx = 1'b1;
  endtask
  initial begin
    int d0, e0;
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'h5A, 1'b0, 0, 1, 8'hFF};
    vecs[5] = '{8'h81, 1'b1, 1, 0, 8'h81};
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(1);
    check("reset data_out", data_out, 0);
    check("reset busy", busy, 0);
    check("reset done", rx_done_tick, 0);
    check("reset err", frame_err_tick, 0);
    wait_cyc(T);
    for (int v = 0; v < 6; v++) begin
      d0 = n_done;
      e0 = n_err;
      send(vecs[v].data, vecs[v].stop);
      wait_cyc(8);
      check($sformatf("vec%0d done", v), n_done - d0, vecs[v].exp_done);
      check($sformatf("vec%0d err", v), n_err - e0, vecs[v].exp_err);
      check($sformatf("vec%0d data_out", v), data_out, vecs[v].exp_dout);
      check($sformatf("vec%0d busy", v), busy, 0);
    end
    d0 = n_done;
    e0 = n_err;
    rx = 1'b0;
    wait_cyc(20);
    check("glitch busy high", busy, 1);
    rx = 1'b1;
    wait_cyc(T);
    check("glitch busy low", busy, 0);
    check("glitch pulses", (n_done - d0) + (n_err - e0), 0);
    check("glitch data_out", data_out, 8'h81);
    got.delete();
    d0 = n_done;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    wait_cyc(8);
    check("b2b count", n_done - d0, 2);
    check("b2b first", got.size() > 0 ? int'(got[0]) : -1, 8'h00);
    check("b2b second", got.size() > 1 ? int'(got[1]) : -1, 8'hFF);
    d0 = n_done;
    e0 = n_err;
    rx = 1'b0;
    wait_cyc(T);
    for (int i = 0; i < 4; i++) begin
      rx = i == 0;
      wait_cyc(T);
    end
    rst = 1'b1;
    rx = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(1);
    check("midreset busy", busy, 0);
    check("midreset data_out", data_out, 0);
    wait_cyc(2 * T);
    check("midreset pulses", (n_done - d0) + (n_err - e0), 0);
    send(8'h3C, 1'b1);
    wait_cyc(8);
    check("after reset done", n_done - d0, 1);
    check("after reset data_out", data_out, 8'h3C);
    d0 = n_done;
    e0 = n_err;
    rx = 1'b0;
    wait_cyc(600);
    check("stuck busy", busy, 1);
    wait_cyc(10 * T - T / 4 - 600);
    rx = 1'b1;
    wait_cyc(2 * T);
    check("stuck err", n_err - e0, 1);
    check("stuck done", n_done - d0, 0);
    check("stuck busy released", busy, 0);
    check("stuck data_out", data_out, 8'h3C);
    check("never both", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
